// File: rtl/sat_divide_pipe.sv
// rtl/sat_divide_pipe.sv - pipelined restoring divider with divide-by-zero and saturation clamp
// One quotient bit per stage; the whole pipe advances together when the output slot is free.
module sat_divide_pipe #(
  parameter int IN_W   = 9,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 16,
  parameter int USER_W = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IN_W-1:0]   i_delta,
  input  logic [IN_W-1:0]   i_value,
  input  logic [USER_W-1:0] i_user,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic [IN_W-1:0]   o_value,
  output logic [USER_W-1:0] o_user,
  output logic              o_dbz,
  output logic              o_sat,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int Q_W = IN_W + FRAC_W;
  localparam int L   = Q_W - 1;

  logic en;
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // Stage s holds the operand before quotient bit s is resolved. qn is a shared
  // shift register: unconsumed dividend bits on top, quotient bits filling from below.
  logic [Q_W-1:0]    vld;
  logic [Q_W-1:0]    qn    [Q_W];
  logic [IN_W-1:0]   dv    [Q_W];
  logic [USER_W-1:0] usr   [Q_W];
  logic [IN_W-1:0]   rem   [1:L];
  logic [IN_W:0]     trial [Q_W];
  logic [Q_W-1:0]    qbit;

  always_comb begin
    trial[0] = {{IN_W{1'b0}}, qn[0][Q_W-1]};
    for (int s = 1; s < Q_W; s++) begin
      trial[s] = {rem[s], qn[s][Q_W-1]};
    end
    qbit = '0;
    for (int s = 0; s < Q_W; s++) begin
      qbit[s] = (trial[s] >= {1'b0, dv[s]});
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[Q_W-2:0], i_valid};
    end
  end

  // Payload registers only load behind a valid token, so bubbles never disturb them.
  always_ff @(posedge i_clk) begin
    if (en) begin
      if (i_valid) begin
        qn[0]  <= Q_W'(i_delta) << FRAC_W;
        dv[0]  <= i_value;
        usr[0] <= i_user;
      end
      for (int s = 1; s < Q_W; s++) begin
        if (vld[s-1]) begin
          rem[s] <= qbit[s-1] ? IN_W'(trial[s-1] - {1'b0, dv[s-1]}) : trial[s-1][IN_W-1:0];
          qn[s]  <= {qn[s-1][Q_W-2:0], qbit[s-1]};
          dv[s]  <= dv[s-1];
          usr[s] <= usr[s-1];
        end
      end
    end
  end

  logic [Q_W-1:0] q_fin;
  logic           dbz;
  logic           sat;

  assign q_fin = {qn[L][Q_W-2:0], qbit[L]};
  assign dbz   = (dv[L] == '0);
  assign sat   = !dbz && ((q_fin >> OUT_W) != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_value <= '0;
      o_user  <= '0;
      o_dbz   <= 1'b0;
      o_sat   <= 1'b0;
    end else if (en) begin
      o_valid <= vld[L];
      if (vld[L]) begin
        o_data  <= (dbz || sat) ? '1 : q_fin[OUT_W-1:0];
        o_value <= dv[L];
        o_user  <= usr[L];
        o_dbz   <= dbz;
        o_sat   <= sat;
      end
    end
  end

endmodule

// File: tb/tb_sat_divide_pipe.sv
// tb/tb_sat_divide_pipe.sv - self-checking bench for sat_divide_pipe
module tb_sat_divide_pipe;

  localparam int IN_W = 9, FRAC_W = 8, OUT_W = 16, USER_W = 1, LAT = 18;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [IN_W-1:0]   i_delta, i_value;
  logic [USER_W-1:0] i_user;
  logic              i_valid, i_ready;
  logic              o_ready, o_dbz, o_sat, o_valid;
  logic [OUT_W-1:0]  o_data;
  logic [IN_W-1:0]   o_value;
  logic [USER_W-1:0] o_user;

  always #5 i_clk = ~i_clk;

  sat_divide_pipe #(.IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .USER_W(USER_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_delta(i_delta), .i_value(i_value), .i_user(i_user),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_value(o_value), .o_user(o_user),
    .o_dbz(o_dbz), .o_sat(o_sat), .o_valid(o_valid), .i_ready(i_ready)
  );

  typedef struct {
    logic [15:0] data;
    logic        dbz;
    logic        sat;
    logic [8:0]  value;
    logic        user;
    int          acc;
    bit          strict;
  } exp_t;

  typedef struct {
    int          d;
    int          v;
    logic [15:0] data;
    logic        dbz;
    logic        sat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0, n_acc = 0;
  bit   strict_lat = 0, ovr = 0;
  logic [15:0] ovr_data;
  logic        ovr_dbz, ovr_sat;
  bit          p_stall = 0;
  logic [15:0] p_data;
  logic [8:0]  p_value;
  logic        p_user, p_dbz, p_sat, p_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input int d, input int v, output logic [15:0] q,
                                output logic dbz, output logic sat);
    int full;
    dbz = 0;
    sat = 0;
    if (v == 0) begin
      q   = 16'hFFFF;
      dbz = 1;
    end else begin
      full = (d * (1 << FRAC_W)) / v;
      if (full > (1 << OUT_W) - 1) begin
        q   = 16'hFFFF;
        sat = 1;
      end else begin
        q = full[15:0];
      end
    end
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 time unit before the rising edge.
  task automatic drive(input logic rst, input logic v, input int d, input int val,
                       input logic u, input logic rdy);
    exp_t e, g;
    @(negedge i_clk);
    i_rst = rst; i_valid = v; i_delta = d[8:0]; i_value = val[8:0]; i_user = u; i_ready = rdy;
    #4;
    cyc++;
    chk("o_ready_rule", o_ready, !o_valid || i_ready);
    if (p_stall) begin
      chk("stall_valid", o_valid, p_valid);
      chk("stall_data", o_data, p_data);
      chk("stall_value", o_value, p_value);
      chk("stall_user", o_user, p_user);
      chk("stall_dbz", o_dbz, p_dbz);
      chk("stall_sat", o_sat, p_sat);
    end
    if (rst) begin
      sb.delete();
    end else begin
      if (o_valid && i_ready) begin
        chk("result_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          g = sb.pop_front();
          chk("data", o_data, g.data);
          chk("dbz", o_dbz, g.dbz);
          chk("sat", o_sat, g.sat);
          chk("value", o_value, g.value);
          chk("user", o_user, g.user);
          if (g.strict) chk("latency", cyc - g.acc, LAT);
        end
      end
      if (i_valid && o_ready) begin
        if (ovr) begin
          e.data = ovr_data; e.dbz = ovr_dbz; e.sat = ovr_sat;
        end else begin
          model(d, val, e.data, e.dbz, e.sat);
        end
        e.value = val[8:0]; e.user = u; e.acc = cyc; e.strict = strict_lat;
        sb.push_back(e);
        n_acc++;
      end
    end
    p_stall = !rst && o_valid && !i_ready;
    p_valid = o_valid; p_data = o_data; p_value = o_value;
    p_user = o_user; p_dbz = o_dbz; p_sat = o_sat;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, $urandom_range(0, 511), $urandom_range(0, 511), 1'($urandom), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() > 0; k++) idle(1);
    chk("drain_empty", sb.size(), 0);
  endtask

  vec_t tbl[$];
  logic [3:0] pat;
  int target;

  initial begin
    i_rst = 1; i_valid = 0; i_delta = 0; i_value = 0; i_user = 0; i_ready = 1;
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 7, 7, 1, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_value", o_value, 0);
    chk("rst_user", o_user, 0);
    chk("rst_dbz", o_dbz, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_ready", o_ready, 1);

    // Directed vectors, issued back-to-back; expected results are hand-computed constants.
    tbl = '{
      '{5, 2, 16'd640, 0, 0}, '{1, 3, 16'd85, 0, 0}, '{0, 3, 16'd0, 0, 0}, '{3, 2, 16'd384, 0, 0},
      '{25, 0, 16'hFFFF, 1, 0}, '{0, 0, 16'hFFFF, 1, 0}, '{511, 1, 16'hFFFF, 0, 1},
      '{255, 1, 16'd65280, 0, 0}, '{256, 1, 16'hFFFF, 0, 1}, '{511, 511, 16'd256, 0, 0},
      '{1, 511, 16'd0, 0, 0}, '{510, 2, 16'd65280, 0, 0}, '{10, 3, 16'd853, 0, 0}
    };
    strict_lat = 1;
    ovr = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      ovr_data = tbl[i].data; ovr_dbz = tbl[i].dbz; ovr_sat = tbl[i].sat;
      drive(0, 1, tbl[i].d, tbl[i].v, 1'(i), 1);
    end
    ovr = 0;
    drain();

    // Bubble pattern 1,0,0,1 must reappear on o_valid LAT cycles later.
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) drive(0, pat[3-k], 100 + k, 7, 0, 1);
    idle(LAT - 4);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk("bubble_valid", o_valid, pat[3-k]);
    end
    drain();

    // Random operands with pseudo-random backpressure.
    strict_lat = 0;
    target = n_acc + 40;
    for (int k = 0; k < 2000 && n_acc < target; k++) begin
      drive(0, ($urandom % 4) != 0, $urandom_range(0, 511),
            ($urandom % 6 == 0) ? 0 : $urandom_range(1, 511), 1'($urandom), 1'($urandom));
    end
    chk("random_issued", n_acc, target);
    drain();

    // Sideband tracking with divisor sweep 1..40.
    strict_lat = 1;
    for (int k = 1; k <= 40; k++) drive(0, 1, $urandom_range(0, 511), k, 1'(k), 1);
    drain();

    // Reset with operands in flight.
    strict_lat = 0;
    for (int k = 0; k < 10; k++) drive(0, 1, $urandom_range(0, 511), $urandom_range(1, 511), 1'(k), 1);
    drive(1, 0, 0, 0, 0, 1);
    strict_lat = 1;
    ovr = 1; ovr_data = 16'd853; ovr_dbz = 0; ovr_sat = 0;
    drive(0, 1, 10, 3, 1, 1);
    ovr = 0;
    chk("post_rst_valid", o_valid, 0);
    for (int k = 0; k < LAT - 1; k++) begin
      idle(1);
      chk("post_rst_quiet", o_valid, 0);
    end
    idle(1);
    chk("post_rst_result_valid", o_valid, 1);
    chk("post_rst_result_data", o_data, 853);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sat_divide_pipe.md
SAT_DIVIDE_PIPE -- requirements
Module: sat_divide_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 9, width of dividend (delta) and divisor (value).
REQ-002 SHALL have parameter FRAC_W, default 8, fractional bits of quotient; quotient width Q_W = IN_W+FRAC_W.
REQ-003 SHALL have parameter OUT_W, default 16, output quotient width (1 <= OUT_W <= Q_W).
REQ-004 SHALL have parameter USER_W, default 1, width of sideband passed through unchanged.
REQ-005 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports i_delta / i_value  input  IN_W each  dividend / divisor, unsigned.
REQ-008 SHALL have port i_user  input  USER_W  sideband, aligned with operands.
REQ-009 SHALL have port i_valid  input  1  operands valid.
REQ-010 SHALL have port o_ready  output  1  block accepts operands this cycle.
REQ-011 SHALL have port o_data  output  OUT_W  quotient, clamped.
REQ-012 SHALL have port o_value  output  IN_W  i_value delayed to match o_data.
REQ-013 SHALL have port o_user  output  USER_W  i_user delayed to match o_data.
REQ-014 SHALL have ports o_dbz / o_sat  output  1 each  divide-by-zero flag / clamp flag.
REQ-015 SHALL have port o_valid  output  1  result valid.
REQ-016 SHALL have port i_ready  input  1  downstream accepts result.

Function
REQ-017 SHALL compute q = floor((i_delta << FRAC_W) / i_value), unsigned, Q_W bits.
REQ-018 SHALL use a pipelined restoring divider, one quotient bit per stage, Q_W stages plus one output register; LATENCY = Q_W+1 cycles (18 at defaults) from accept to o_valid with i_ready held high.
REQ-019 SHALL accept a transfer when i_valid && o_ready; transfer out when o_valid && i_ready.
REQ-020 SHALL advance all stages together on enable en = !o_valid || i_ready; o_ready = en.
REQ-021 SHALL sustain throughput of one result per cycle with i_ready held high.
REQ-022 SHALL hold o_data, o_value, o_user, o_dbz, o_sat, o_valid stable while o_valid && !i_ready; no operand lost or duplicated.
REQ-023 SHALL carry a per-stage valid bit; bubbles (i_valid low on accept cycle) propagate as invalid and never assert o_valid.
REQ-024 SHALL on i_value == 0 drive o_data = all ones, o_dbz = 1, o_sat = 0, regardless of i_delta (including 0/0).
REQ-025 SHALL on q > 2^OUT_W-1 (nonzero divisor) drive o_data = all ones, o_sat = 1, o_dbz = 0; otherwise o_data = q[OUT_W-1:0], both flags 0.
REQ-026 SHALL keep results in input order; o_value and o_user SHALL be the values presented with the same operand.
REQ-027 SHALL ignore operand and sideband inputs when the accept condition is false.

Reset
REQ-028 SHALL on i_rst high clear all stage valid bits and drive o_valid = 0, o_data = 0, o_value = 0, o_user = 0, o_dbz = 0, o_sat = 0, o_ready = 1 at the next edge.
REQ-029 SHALL on reset mid-operation discard all in-flight operands; no o_valid until a new accept occurs at least LATENCY cycles after reset release.
REQ-030 SHALL accept operands in the first cycle after i_rst deasserts.

Verification (defaults IN_W=9, FRAC_W=8, OUT_W=16, i_ready=1 unless stated)
REQ-031 Directed divides 5/2, 1/3, 0/3, 3/2 issued back-to-back -> o_data 640, 85, 0, 384 on consecutive cycles, first 18 cycles after the first accept, flags 0.
REQ-032 Divides 25/0 and 0/0 -> o_data 0xFFFF, o_dbz=1, o_sat=0; 511/1 -> o_data 0xFFFF, o_sat=1, o_dbz=0.
REQ-033 Stream 40 random operands, i_ready toggled pseudo-randomly -> every result matches the reference model in order; outputs stable during stall; o_ready == !o_valid || i_ready every cycle.
REQ-034 Sideband: i_user toggling per operand, i_value 1..40 -> o_user and o_value match the originating operand for each result.
REQ-035 Assert i_rst for 1 cycle with 10 operands in flight -> o_valid 0 next cycle and stays 0; 10/3 issued after release -> o_data 853 exactly 18 cycles later.
REQ-036 Bubble pattern (i_valid 1,0,0,1) -> o_valid pattern 1,0,0,1 delayed by 18 cycles.
